fir_inverse_filter: RTL

// - Decoder for the 4-tap low-pass FIR: rebuilds the 8-bit input samples x from the 16-bit filtered stream y.
// - Sits at the receive end of the filtered sample path. Used for loopback self-test and for exact recovery of the source.
// - Uses the recursion x[n] = (y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3]) / H0, with H0 fixed at 1.
// - Detects y values that are not consistent with any int8 input sequence, and then holds in a fault state.

---
 rtl/fir_inverse_filter.sv | 99 +++++++++
 1 files changed

// File: rtl/fir_inverse_filter.sv
// Inverse of the 4-tap low-pass FIR: rebuilds int8 source samples from the filtered
// 16-bit stream, flags samples no int8 sequence could have produced, and holds in FAULT.
module fir_inverse_filter #(
  parameter logic signed [7:0] H0 = 8'sd1,
  parameter logic signed [7:0] H1 = 8'sd2,
  parameter logic signed [7:0] H2 = 8'sd2,
  parameter logic signed [7:0] H3 = 8'sd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] y_in,
  input  logic               y_valid,
  input  logic               resync,
  output logic signed [7:0]  x_out,
  output logic               x_valid,
  output logic               err,
  output logic [7:0]         err_count,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Division by H0 is omitted from the datapath, so any other value would decode wrongly.
  generate
    if (H0 != 8'sd1) begin : g_h0_check
      $error("fir_inverse_filter: H0 must be 1");
    end
  endgenerate

  state_t            r_state;
  logic signed [7:0] r_hist1, r_hist2, r_hist3;
  logic signed [7:0] r_x_out;
  logic              r_x_valid;
  logic              r_err;
  logic [7:0]        r_err_count;

  logic signed [18:0] w_y_ext;
  logic signed [18:0] w_p1, w_p2, w_p3;
  logic signed [18:0] w_e;
  logic               w_consistent;
  logic               w_accept;

  // 19 bits holds |y| + 6*128*128 headroom, so e is exact before the range check.
  assign w_y_ext      = 19'(y_in);
  assign w_p1         = 19'(H1) * 19'(r_hist1);
  assign w_p2         = 19'(H2) * 19'(r_hist2);
  assign w_p3         = 19'(H3) * 19'(r_hist3);
  assign w_e          = w_y_ext - (w_p1 + w_p2 + w_p3);
  assign w_consistent = (w_e >= -19'sd128) && (w_e <= 19'sd127);
  assign w_accept     = y_valid && !resync && (r_state != ST_FAULT);

  // NOTE: every register below is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = here would let r_hist2 see the new r_hist1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hist1     <= '0;
      r_hist2     <= '0;
      r_hist3     <= '0;
      r_x_out     <= '0;
      r_x_valid   <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_x_valid <= 1'b0;
      if (resync) begin
        r_hist1 <= '0;
        r_hist2 <= '0;
        r_hist3 <= '0;
        r_state <= ST_IDLE;
      end else if (w_accept) begin
        r_x_out   <= w_e[7:0];
        r_x_valid <= 1'b1;
        if (w_consistent) begin
          r_hist1 <= w_e[7:0];
          r_hist2 <= r_hist1;
          r_hist3 <= r_hist2;
          r_state <= ST_RUN;
        end else begin
          // The bad sample is still emitted so the receiver sees where the stream broke.
          r_err       <= 1'b1;
          r_err_count <= (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
          r_state     <= ST_FAULT;
        end
      end
    end
  end

  assign x_out     = r_x_out;
  assign x_valid   = r_x_valid;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign state_o   = r_state;

endmodule
